// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver.
//   parity_e      : decoded parity setting (none / even / odd)
//   rx_state_e    : receiver FSM states
//   MIN_BAUD_DIV  : smallest usable clocks-per-bit divisor
//   clamp_baud    : raises divisors below MIN_BAUD_DIV to MIN_BAUD_DIV
//   decode_parity : maps the 2-bit parity_mode input onto parity_e
package uart_pkg;

  localparam int unsigned MIN_BAUD_DIV = 4;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  function automatic logic [31:0] clamp_baud(input logic [31:0] div);
    if (div < 32'(MIN_BAUD_DIV)) begin
      return 32'(MIN_BAUD_DIV);
    end
    return div;
  endfunction

  // Encoding 2'b11 is reserved and behaves as "no parity".
  function automatic parity_e decode_parity(input logic [1:0] mode);
    case (mode)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Signal bundle between a UART receiver and its user.
//   baud_rate   : clocks per bit period
//   parity_mode : 00 none, 01 even, 10 odd, 11 none
//   stop_bits   : 0 one stop bit, 1 two stop bits
//   uart_rx     : asynchronous serial line, idle high, LSB first
//   rx_data     : last received word, held until the next rx_valid
//   rx_valid    : one-cycle pulse per completed frame
//   rx_error    : parity or framing error, qualified by rx_valid
//   rx_busy     : receiver is inside a frame
// Modport slave is the receiver; modport master is the user/line driver.
interface uart_rx_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic [31:0]           baud_rate;
  logic [1:0]            parity_mode;
  logic                  stop_bits;
  logic                  uart_rx;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_error;
  logic                  rx_busy;

  modport slave (
    input  baud_rate,
    input  parity_mode,
    input  stop_bits,
    input  uart_rx,
    output rx_data,
    output rx_valid,
    output rx_error,
    output rx_busy
  );

  modport master (
    output baud_rate,
    output parity_mode,
    output stop_bits,
    output uart_rx,
    input  rx_data,
    input  rx_valid,
    input  rx_error,
    input  rx_busy
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus falling-edge detection.
//   clk       : clock
//   rst       : synchronous active-high reset
//   rx_i      : raw asynchronous serial line
//   rx_sync_o : synchronized line level
//   fall_o    : synchronized 1->0 transition seen this cycle
// Both synchronizer flops reset to 1. The edge detector only reports a fall
// once a genuine high has come out of the synchronizer after reset, so a line
// that is low through and out of reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic rx_sync_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  // fill_q[1] is set once sync_q[1] holds a real line sample, not a reset value.
  logic [1:0] fill_q;
  // Previous synchronized sample, forced low until it is a real high.
  logic       prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
      fill_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      fill_q <= {fill_q[0], 1'b1};
      prev_q <= fill_q[1] & sync_q[1];
    end
  end

  always_comb begin
    rx_sync_o = sync_q[1];
    fall_o    = prev_q & ~sync_q[1];
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-bit qualification, DATA_WIDTH data bits LSB first,
// optional even/odd parity, one or two stop bits.
//   clk : clock
//   rst : synchronous active-high reset, aborts any frame in progress
//   bus : uart_rx_if slave modport (configuration, serial line, results)
// Configuration is latched at start-bit detection and held for the frame.
// The baud counter counts down to zero and reloads on every sample, so it
// never wraps inside a bit period.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int unsigned BitCntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic                  rx_s;
  logic                  fall;

  rx_state_e             state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [31:0]           baud_q, baud_d;
  parity_e               par_q, par_d;
  logic                  two_stop_q, two_stop_d;
  logic                  par_err_q, par_err_d;
  logic                  frm_err_q, frm_err_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rx_error_q, rx_error_d;

  logic [31:0]           baud_eff;
  logic                  tick;

  uart_rx_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .rx_i      (bus.uart_rx),
    .rx_sync_o (rx_s),
    .fall_o    (fall)
  );

  assign baud_eff = clamp_baud(bus.baud_rate);
  assign tick     = (cnt_q == 32'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      baud_q     <= '0;
      par_q      <= PAR_NONE;
      two_stop_q <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      baud_q     <= baud_d;
      par_q      <= par_d;
      two_stop_q <= two_stop_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_error_q <= rx_error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    baud_d     = baud_q;
    par_d      = par_q;
    two_stop_d = two_stop_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_error_d = rx_error_q;

    unique case (state_q)
      StIdle: begin
        if (fall) begin
          state_d    = StStart;
          baud_d     = baud_eff;
          // The detection cycle counts toward the half-bit wait, hence -2.
          cnt_d      = (baud_eff >> 1) - 32'd2;
          par_d      = decode_parity(bus.parity_mode);
          two_stop_d = bus.stop_bits;
          par_err_d  = 1'b0;
          frm_err_d  = 1'b0;
        end
      end

      StStart: begin
        if (tick) begin
          if (rx_s) begin
            // Line back high at mid start bit: glitch, not a frame.
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            state_d   = StData;
            cnt_d     = baud_q - 32'd1;
            bit_cnt_d = BitCntW'(DATA_WIDTH - 1);
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end

      StData: begin
        if (tick) begin
          shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
          cnt_d   = baud_q - 32'd1;
          if (bit_cnt_q == '0) begin
            if (par_q != PAR_NONE) begin
              state_d = StParity;
            end else begin
              state_d   = StStop;
              bit_cnt_d = two_stop_q ? BitCntW'(1) : '0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q - BitCntW'(1);
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end

      StParity: begin
        if (tick) begin
          // XOR over data and parity bit must be 0 for even, 1 for odd.
          par_err_d = ((^shift_q) ^ rx_s) != (par_q == PAR_ODD);
          state_d   = StStop;
          bit_cnt_d = two_stop_q ? BitCntW'(1) : '0;
          cnt_d     = baud_q - 32'd1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end

      StStop: begin
        if (tick) begin
          if (!rx_s) begin
            frm_err_d = 1'b1;
          end
          if (bit_cnt_q == '0) begin
            state_d    = StIdle;
            cnt_d      = '0;
            rx_valid_d = 1'b1;
            rx_data_d  = shift_q;
            rx_error_d = par_err_q | frm_err_q | ~rx_s;
          end else begin
            bit_cnt_d = bit_cnt_q - BitCntW'(1);
            cnt_d     = baud_q - 32'd1;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_error = rx_error_q;
  assign bus.rx_busy  = (state_q != StIdle);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 baud_rate  input  32  clock cycles per bit period (divisor); values below 4 treated as 4.
REQ-005 parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none.
REQ-006 stop_bits  input  1  0 = one stop bit, 1 = two stop bits.
REQ-007 uart_rx  input  1  asynchronous serial line, idle high, LSB-first frames.
REQ-008 rx_data  output  DATA_WIDTH  last received data word, held until next rx_valid.
REQ-009 rx_valid  output  1  single-cycle pulse marking a completed frame.
REQ-010 rx_error  output  1  qualified by rx_valid: parity error OR framing error.
REQ-011 rx_busy  output  1  high from start-bit detection until return to IDLE.

Function
REQ-012 uart_rx SHALL pass through a 2-flop synchronizer, both flops resetting to 1; all decisions use the synchronized value.
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; a bit counter tracks DATA bits and stop bits.
REQ-014 IDLE: a synchronized 1->0 transition SHALL enter START and latch baud_rate, parity_mode, stop_bits; later config changes are ignored until IDLE.
REQ-015 Line held low at or out of reset SHALL NOT trigger a frame; a high sample must precede the falling edge.
REQ-016 START: after baud_rate/2 (floor) cycles, sample; 1 = false start -> IDLE, no rx_valid; 0 -> DATA.
REQ-017 DATA: sample every baud_rate cycles, DATA_WIDTH samples, shifted in LSB first.
REQ-018 PARITY (entered only if parity enabled): one sample; even mode expects XOR(data, parity) = 0, odd mode expects 1; mismatch sets parity error.
REQ-019 STOP: one or two samples at baud_rate spacing; any 0 sample sets framing error; sampling all stop bits still completes.
REQ-020 One cycle after the final stop sample, rx_valid SHALL pulse high for exactly 1 cycle with rx_data and rx_error updated in that same cycle, and FSM returns to IDLE.
REQ-021 A framing error with line still low SHALL NOT start a new frame until the line is seen high (per REQ-015).
REQ-022 The baud counter SHALL be 32 bits, reload on every sample, and never wrap within a bit period.
REQ-023 A falling edge in the same cycle as rx_valid SHALL be accepted as the next start bit (back-to-back frames).
REQ-024 rx_busy SHALL be 1 in START, DATA, PARITY, STOP and 0 in IDLE.

Reset
REQ-025 rst SHALL, in any state including mid-frame, force IDLE, rx_data=0, rx_valid=0, rx_error=0, rx_busy=0, counters=0, synchronizer=1, with no rx_valid for the aborted frame.
REQ-026 First start bit SHALL be recognizable no earlier than 3 cycles after rst deasserts.

Structure
REQ-027 Shared package uart_pkg SHALL hold the parity enum (PAR_NONE, PAR_EVEN, PAR_ODD), the rx state enum, and constant MIN_BAUD_DIV = 4.
REQ-028 One sub-module uart_rx_sync SHALL implement the 2-flop synchronizer plus falling-edge detect; the FSM, counters and shifter live in uart_rx.

Verification
REQ-029 baud_rate=16, 8N1, send 0xA5 -> one rx_valid, rx_data=0xA5, rx_error=0, pulse about 152 cycles (9.5 bits) after the falling edge, within +/-4 cycles.
REQ-030 baud_rate=16, even parity, send 0x07 with parity bit 0 -> rx_data=0x07, rx_error=1; repeat with parity bit 1 -> rx_error=0.
REQ-031 baud_rate=10, 2 stop bits, second stop bit driven 0 -> rx_valid with rx_error=1; line held low -> no further rx_valid until the line returns high.
REQ-032 4-cycle low glitch on idle line, baud_rate=16 -> no rx_valid, rx_busy returns to 0 within 9 cycles.
REQ-033 Assert rst during DATA bit 3 of 0x3C -> no rx_valid, all outputs 0; next frame 0xC3 -> rx_data=0xC3, rx_error=0.
REQ-034 Back-to-back frames 0x55, 0xAA at baud_rate=4, odd parity, no idle gap -> two rx_valid pulses, data correct, rx_error=0 both.
